// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the two-byte UART command framing.
// CMD_FRAME_TX_CHECKSUM_EN adds the XOR checksum byte states.
package cmd_frame_pkg;

    localparam logic [7:0] CMD_IDLE_BYTE = 8'h00;
    localparam int         ENTRY_W       = 16;

    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CMD,
        ST_WAIT_DATA
`ifdef CMD_FRAME_TX_CHECKSUM_EN
        ,
        ST_SEND_SUM,
        ST_WAIT_SUM
`endif
    } tx_state_e;

    function automatic logic [7:0] frame_sum(input entry_t e);
        return e.cmd ^ e.data;
    endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Request handshake between an on-chip initiator and cmd_frame_tx.
// The master drives requests; the slave answers with ready and err.
interface cmd_frame_tx_if;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cmd;
    logic [7:0] req_data;
    logic       req_err;

    modport master (
        output req_valid, req_cmd, req_data,
        input  req_ready, req_err
    );

    modport slave (
        input  req_valid, req_cmd, req_data,
        output req_ready, req_err
    );

endinterface

// File: rtl/cmd_frame_fifo.sv
// Synchronous request FIFO with occupancy count.
// Push and pop may occur together; pointers wrap on a power-of-two depth.
module cmd_frame_fifo
    import cmd_frame_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; simultaneous push/pop leaves count as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Frames buffered (cmd, data) requests into paced UART byte sends.
// CMD_FRAME_TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
module cmd_frame_tx
    import cmd_frame_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    cmd_frame_tx_if.slave                 req,
    input  logic                          uart_busy,
    output logic                          uart_send,
    output logic [7:0]                    uart_data_in,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          idle
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    tx_state_e     state, state_n;
    logic [GW-1:0] guard, guard_n;
    logic          send_n;
    logic [7:0]    byte_n;
    logic [7:0]    cur_data, cur_data_n;
    logic          accept, push, pop;
    logic          full, empty, err_q;
    entry_t        head;
    entry_t        din;
`ifdef CMD_FRAME_TX_CHECKSUM_EN
    logic [7:0]    cur_sum, cur_sum_n;
`endif

    assign accept = req.req_valid && req.req_ready;
    assign push   = accept && (req.req_cmd != CMD_IDLE_BYTE);
    assign din    = '{cmd: req.req_cmd, data: req.req_data};

    assign req.req_ready = !full;
    assign req.req_err   = err_q;
    assign idle          = empty && (state == ST_IDLE);

    cmd_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Frame sequencing: send a byte, wait out the guard, then wait for !busy.
    always_comb begin
        state_n    = state;
        guard_n    = guard;
        send_n     = 1'b0;
        byte_n     = uart_data_in;
        cur_data_n = cur_data;
        pop        = 1'b0;
`ifdef CMD_FRAME_TX_CHECKSUM_EN
        cur_sum_n  = cur_sum;
`endif
        unique case (state)
            ST_IDLE: begin
                if (!empty && !uart_busy) begin
                    pop        = 1'b1;
                    cur_data_n = head.data;
                    byte_n     = head.cmd;
                    send_n     = 1'b1;
                    guard_n    = GUARD_LOAD;
                    state_n    = ST_WAIT_CMD;
`ifdef CMD_FRAME_TX_CHECKSUM_EN
                    cur_sum_n  = frame_sum(head);
`endif
                end
            end
            ST_WAIT_CMD: begin
                if (guard != '0) begin
                    guard_n = guard - 1'b1;
                end else if (!uart_busy) begin
                    byte_n  = cur_data;
                    send_n  = 1'b1;
                    guard_n = GUARD_LOAD;
                    state_n = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (guard != '0) begin
                    guard_n = guard - 1'b1;
                end else if (!uart_busy) begin
`ifdef CMD_FRAME_TX_CHECKSUM_EN
                    state_n = ST_SEND_SUM;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
`ifdef CMD_FRAME_TX_CHECKSUM_EN
            ST_SEND_SUM: begin
                if (!uart_busy) begin
                    byte_n  = cur_sum;
                    send_n  = 1'b1;
                    guard_n = GUARD_LOAD;
                    state_n = ST_WAIT_SUM;
                end
            end
            ST_WAIT_SUM: begin
                if (guard != '0) begin
                    guard_n = guard - 1'b1;
                end else if (!uart_busy) begin
                    state_n = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    // State, guard counter and registered UART outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            guard        <= '0;
            uart_send    <= 1'b0;
            uart_data_in <= 8'h00;
            cur_data     <= 8'h00;
            err_q        <= 1'b0;
`ifdef CMD_FRAME_TX_CHECKSUM_EN
            cur_sum      <= 8'h00;
`endif
        end else begin
            state        <= state_n;
            guard        <= guard_n;
            uart_send    <= send_n;
            uart_data_in <= byte_n;
            cur_data     <= cur_data_n;
            err_q        <= accept && (req.req_cmd == CMD_IDLE_BYTE);
`ifdef CMD_FRAME_TX_CHECKSUM_EN
            cur_sum      <= cur_sum_n;
`endif
        end
    end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Self-checking bench for cmd_frame_tx with a busy-holding UART model.
// Expected byte streams come from a frame-level model (cmd, data[, cmd^data]).
module tb_cmd_frame_tx;

    localparam int DEPTH = 4;
    localparam int GUARD = 2;
`ifdef CMD_FRAME_TX_CHECKSUM_EN
    localparam int FLEN = 3;
`else
    localparam int FLEN = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_busy;
    logic       uart_send;
    logic [7:0] uart_data_in;
    logic [2:0] fifo_count;
    logic       idle;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int  busy_len = 0;
    bit  busy_force = 1'b0;
    int  busy_cnt = 0;
    bit  prev_send = 1'b0;
    logic [7:0] last_byte = 8'h00;

    logic [7:0] got[$];
    int         tstamp[$];
    logic [7:0] exp_q[$];

    cmd_frame_tx_if rif ();

    cmd_frame_tx #(
        .FIFO_DEPTH   (DEPTH),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .req          (rif),
        .uart_busy    (uart_busy),
        .uart_send    (uart_send),
        .uart_data_in (uart_data_in),
        .fifo_count   (fifo_count),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Cycle stamp, advanced on every active edge.
    always @(posedge clk) cyc++;

    // UART model and line monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt  = 0;
            prev_send = 1'b0;
            last_byte = 8'h00;
        end else begin
            if (uart_send) begin
                checks++;
                if (prev_send) begin
                    errors++;
                    $display("FAIL send_twice: uart_send high two cycles at cyc %0d", cyc);
                end
                got.push_back(uart_data_in);
                tstamp.push_back(cyc);
                last_byte = uart_data_in;
                busy_cnt  = busy_len;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                checks++;
                if (uart_data_in !== last_byte) begin
                    errors++;
                    $display("FAIL data_stable: uart_data_in=%h without send, held %h",
                             uart_data_in, last_byte);
                end
            end
            prev_send = uart_send;
        end
        uart_busy = busy_force || (busy_cnt > 0);
    end

    function automatic void model_frame(input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(c);
        exp_q.push_back(d);
        if (FLEN == 3) exp_q.push_back(c ^ d);
    endfunction

    task automatic clear_logs();
        got.delete();
        tstamp.delete();
        exp_q.delete();
    endtask

    task automatic drive_req(input logic [7:0] c, input logic [7:0] d, output bit ok);
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_cmd   = c;
        rif.req_data  = d;
        for (int i = 0; i < 500; i++) begin
            if (rif.req_ready) break;
            @(negedge clk);
        end
        ok = rif.req_ready;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got.size() >= n) break;
            @(negedge clk);
        end
        checks++;
        if (got.size() < n) begin
            errors++;
            $display("FAIL byte_timeout: got %0d bytes, need %0d", got.size(), n);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (idle) break;
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL idle_after: idle=%b need 1", idle);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rif.req_valid = 1'b0;
        rif.req_cmd = 8'h00;
        rif.req_data = 8'h00;
        repeat (3) @(negedge clk);
        checks += 6;
        if (uart_send !== 1'b0) begin errors++; $display("FAIL rst_send: %b need 0", uart_send); end
        if (uart_data_in !== 8'h00) begin errors++; $display("FAIL rst_data: %h need 00", uart_data_in); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: %0d need 0", fifo_count); end
        if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: %b need 1", idle); end
        if (rif.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: %b need 1", rif.req_ready); end
        if (rif.req_err !== 1'b0) begin errors++; $display("FAIL rst_err: %b need 0", rif.req_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int acc;
        clear_logs();
        busy_len = 0;
        drive_req(8'hE2, 8'h5A, ok);
        acc = cyc;
        model_frame(8'hE2, 8'h5A);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_accept: ready=0 need 1"); end
        wait_bytes(FLEN, 60);
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: %h need %h", i, got[i], exp_q[i]);
            end
        end
        if (tstamp.size() >= 2) begin
            checks += 2;
            if (tstamp[1] - tstamp[0] != GUARD + 1) begin
                errors++;
                $display("FAIL basic_gap: %0d need %0d", tstamp[1] - tstamp[0], GUARD + 1);
            end
            if (tstamp[0] - acc < 1 || tstamp[0] - acc > 2) begin
                errors++;
                $display("FAIL basic_latency: %0d need 1..2", tstamp[0] - acc);
            end
        end
        wait_idle();
    endtask

    task automatic test_zero_data();
        bit ok;
        clear_logs();
        busy_len = 100;
        drive_req(8'hE3, 8'h00, ok);
        model_frame(8'hE3, 8'h00);
        wait_bytes(FLEN, 600);
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_data_byte%0d: %h need %h", i, got[i], exp_q[i]);
            end
        end
        if (tstamp.size() >= 2) begin
            checks++;
            if (tstamp[1] - tstamp[0] < 100) begin
                errors++;
                $display("FAIL zero_data_gap: %0d need >=100", tstamp[1] - tstamp[0]);
            end
        end
        wait_idle();
    endtask

    task automatic test_full();
        bit ok;
        bit stuck;
        clear_logs();
        busy_len = 3;
        busy_force = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < DEPTH; k++) begin
            drive_req(8'hE0 + 8'(k), 8'h01 + 8'(k), ok);
            model_frame(8'hE0 + 8'(k), 8'h01 + 8'(k));
            checks++;
            if (!ok) begin errors++; $display("FAIL full_accept%0d: ready=0 need 1", k); end
        end
        @(negedge clk);
        checks += 2;
        if (rif.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: %b need 0", rif.req_ready); end
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: %0d need 4", fifo_count); end
        rif.req_valid = 1'b1;
        rif.req_cmd = 8'hE4;
        rif.req_data = 8'h05;
        stuck = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rif.req_ready !== 1'b0) stuck = 1'b1;
        end
        rif.req_valid = 1'b0;
        checks++;
        if (stuck) begin errors++; $display("FAIL full_hold: ready rose while full, need 0"); end
        busy_force = 1'b0;
        wait_bytes(DEPTH * FLEN, 600);
        for (int i = 0; i < DEPTH * FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_byte%0d: %h need %h", i, got[i], exp_q[i]);
            end
        end
        wait_idle();
        checks++;
        if (got.size() != DEPTH * FLEN) begin
            errors++;
            $display("FAIL full_total: %0d bytes need %0d", got.size(), DEPTH * FLEN);
        end
    endtask

    task automatic test_zero_cmd();
        bit ok;
        int pulses;
        bit cnt_bad;
        clear_logs();
        busy_len = 0;
        drive_req(8'h00, 8'h77, ok);
        pulses = 0;
        cnt_bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rif.req_err === 1'b1) pulses++;
            if (fifo_count !== 3'd0) cnt_bad = 1'b1;
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL zcmd_err: %0d pulses need 1", pulses); end
        if (cnt_bad) begin errors++; $display("FAIL zcmd_count: nonzero need 0"); end
        if (got.size() != 0) begin errors++; $display("FAIL zcmd_send: %0d bytes need 0", got.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        busy_len = 10;
        drive_req(8'hE5, 8'h11, ok);
        wait_bytes(1, 60);
        checks++;
        if (got.size() > 0 && got[0] !== 8'hE5) begin
            errors++;
            $display("FAIL mid_first: %h need e5", got[0]);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (uart_send !== 1'b0) begin errors++; $display("FAIL mid_send: %b need 0", uart_send); end
        if (uart_data_in !== 8'h00) begin errors++; $display("FAIL mid_data: %h need 00", uart_data_in); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: %0d need 0", fifo_count); end
        if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: %b need 1", idle); end
        if (rif.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: %b need 1", rif.req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        busy_len = 0;
        @(negedge clk);
        drive_req(8'hE6, 8'h22, ok);
        model_frame(8'hE6, 8'h22);
        wait_bytes(FLEN, 60);
        repeat (20) @(negedge clk);
        checks++;
        if (got.size() != FLEN) begin
            errors++;
            $display("FAIL mid_total: %0d bytes need %0d", got.size(), FLEN);
        end
        for (int i = 0; i < FLEN && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_byte%0d: %h need %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] c, d;
        clear_logs();
        for (int k = 0; k < 8; k++) begin
            c = 8'($urandom_range(1, 255));
            d = 8'($urandom_range(0, 255));
            busy_len = $urandom_range(0, 6);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_req(c, d, ok);
            model_frame(c, d);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_accept%0d: ready=0 need 1", k); end
        end
        wait_bytes(exp_q.size(), 2000);
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_byte%0d: %h need %h", i, got[i], exp_q[i]);
            end
        end
        wait_idle();
    endtask

    initial begin
        uart_busy = 1'b0;
        test_reset();
        test_basic();
        test_zero_data();
        test_full();
        test_zero_cmd();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_frame_tx.md
# cmd_frame_tx

Transmit-side encoder for the two-byte UART command protocol (non-zero command byte followed by one data byte) consumed by the board's command parser. Buffers (command, data) requests in a small FIFO and drives them, byte by byte, into the `uart_hs` transmit port (`uart_send` / `uart_data_in`). It paces transmission on the UART busy flag. It sits between any on-chip initiator (test sequencer, reply logic, a second FPGA link) and the UART transmitter.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `GUARD_CYCLES`, 2: minimum cycles after each `uart_send` pulse before `uart_busy` is sampled; ≥1.
- `sys_clk`  in  1  single clock for all logic.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept; transfer on `req_valid & req_ready`.
- `req_cmd`  in  8  command byte; must be non-zero.
- `req_data`  in  8  data byte.
- `req_err`  out  1  one-cycle pulse: request with `req_cmd==0` was dropped.
- `uart_busy`  in  1  UART transmitter busy shifting a byte.
- `uart_send`  out  1  one-cycle pulse: load `uart_data_in` into UART.
- `uart_data_in`  out  8  byte to transmit; held stable until the next pulse.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `idle`  out  1  FIFO empty and FSM in IDLE.

## Operation
- Reset values: `req_ready`=1, `req_err`=0, `uart_send`=0, `uart_data_in`=0x00, `fifo_count`=0, `idle`=1, FSM=IDLE, guard counter=0.
- `req_ready` = !full. It does not look ahead on a same-cycle pop.
- Accepted request with `req_cmd!=0`: pushed as a 16-bit entry {cmd,data}.
- Accepted request with `req_cmd==0`: not pushed. `req_err` pulses the next cycle. Reason: the parser treats 0x00 in the command slot as idle fill.
- Push and pop in the same cycle: both happen and the count is unchanged.
- FSM states:
  - IDLE: if FIFO not empty and `uart_busy`=0 → pop, `uart_data_in`<=cmd, `uart_send`<=1, load guard, go to WAIT_CMD.
  - WAIT_CMD: the guard counter counts down. At 0, with `uart_busy`=0 → `uart_data_in`<=data, `uart_send`<=1, reload guard, go to WAIT_DATA.
  - WAIT_DATA: at guard 0 with `uart_busy`=0 → go to IDLE (or SEND_SUM, see Configuration).
- The data byte of a frame always immediately follows its command byte. Frames are never interleaved or split by new requests.
- The data byte is unrestricted (0x00–0xFF).
- Reset mid-frame aborts at once. No recovery byte is sent; the parser shares `sys_rst_n`.

## Timing
- Request accepted at edge N. The entry is visible at N+1. The `uart_send` for cmd is high in cycle N+2 if the UART is idle.
- The `uart_send` for data comes no earlier than GUARD_CYCLES+1 cycles after the cmd pulse, and only once `uart_busy` is low.
- Back-to-back frames: the next cmd pulse comes no earlier than the first cycle after WAIT_DATA exits with `uart_busy`=0.
- `uart_send` is never high for two consecutive cycles.
- `uart_data_in` changes only on the edge that raises `uart_send`.

## Configuration
- `CMD_FRAME_TX_CHECKSUM_EN`
- Defined: a third byte, the XOR of cmd and data, follows each frame. This adds states SEND_SUM and WAIT_SUM with the same guard/busy rules; WAIT_DATA goes to SEND_SUM.
- Undefined: frames are exactly two bytes and no SUM states exist.

## Structure
- Shared package `cmd_frame_pkg`:
  - FSM state encoding.
  - Constant `CMD_IDLE_BYTE` = 8'h00.
  - Entry width 16.
- The same package is reused by the receiver-side parser.
- One sub-module, `cmd_frame_fifo`: synchronous FIFO with count, full/empty, and simultaneous push/pop.

## Test plan
- Push (E2, 5A) with `uart_busy` tied low → `uart_send` pulses carrying 0xE2, then 0x5A, exactly 1+GUARD_CYCLES cycles apart.
- Push (E3, 00) while the UART model holds busy for 100 cycles per byte → 0x00 data is sent and never dropped; the second pulse comes ≥100 cycles after the first.
- Push FIFO_DEPTH+1 requests back-to-back with the UART busy → `req_ready` drops after 4. All 4 frames go out in order (E0,01 / E1,02 / E2,03 / E3,04) with no interleaving.
- Push (00, 77) → `req_err` pulses once, `fifo_count` stays 0, and there is no `uart_send`.
- Assert `sys_rst_n`=0 between the cmd and data bytes → all outputs return to reset values asynchronously. After release the next frame starts cleanly.
- With `CMD_FRAME_TX_CHECKSUM_EN`, push (E2, 5A) → bytes 0xE2, 0x5A, 0xB8.
